// File: rtl/joojump_input_conditioner.sv
// JooJump button front-end: 2-flop sync, per-button debounce with press pulses,
// and a pausable, clearable tick counter.

module joojump_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic s,
  output logic level,
  output logic pulse,
  output logic pulse_nxt
);
  localparam int CW = $clog2(DB_CYCLES);

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    case (state_q)
      RELEASED: if (s) begin
        state_d = PRESS_WAIT;
        cnt_d   = CW'(1);
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: if (!s) begin
        state_d = RELEASE_WAIT;
        cnt_d   = CW'(1);
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
          state_d = RELEASED;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level     = level_q;
  assign pulse     = pulse_q;
  assign pulse_nxt = pulse_d;
endmodule

module joojump_input_conditioner #(
  parameter int DB_CYCLES = 1000000,
  parameter int TICK_DIV  = 50000,
  parameter int CNT_W     = 8
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [2:0]       key_n,
  output logic             jump_button_export,
  output logic             pause_button_export,
  output logic             reset_button_export,
  output logic [2:0]       press_pulse,
  output logic [CNT_W-1:0] counter_8bit_export
);
  localparam int NUM_LANES = 3;
  localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Sync flops carry the raw active-low level so reset means "released".
  logic [NUM_LANES-1:0] sync1_q, sync2_q;
  logic [NUM_LANES-1:0] level, pulse_nxt;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  joojump_debounce #(.DB_CYCLES(DB_CYCLES)) u_db [NUM_LANES-1:0] (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .s            (~sync2_q),
    .level        (level),
    .pulse        (press_pulse),
    .pulse_nxt    (pulse_nxt)
  );

  assign jump_button_export  = level[0];
  assign pause_button_export = level[1];
  assign reset_button_export = level[2];

  logic [PW-1:0]    pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The clear lands on the edge the reset press is accepted, so the zeroed
  // counter and the reset pulse become visible together.
  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (pulse_nxt[2]) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (!level[1]) begin
      if (pre_q == PW'(TICK_DIV - 1)) begin
        pre_d = '0;
        cnt_d = cnt_q + 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  assign counter_8bit_export = cnt_q;
endmodule

// File: tb/tb_joojump_input_conditioner.sv
// Directed + random bench for joojump_input_conditioner against a
// run-length behavioural model of the buttons and tick counter.

module tb_joojump_input_conditioner;
  localparam int DB = 4;
  localparam int TD = 3;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [2:0] key_n;
  logic       jump_button_export, pause_button_export, reset_button_export;
  logic [2:0] press_pulse;
  logic [7:0] counter_8bit_export;

  joojump_input_conditioner #(.DB_CYCLES(DB), .TICK_DIV(TD), .CNT_W(8)) dut (
    .clk_clk            (clk_clk),
    .reset_reset_n      (reset_reset_n),
    .key_n              (key_n),
    .jump_button_export (jump_button_export),
    .pause_button_export(pause_button_export),
    .reset_button_export(reset_button_export),
    .press_pulse        (press_pulse),
    .counter_8bit_export(counter_8bit_export)
  );

  always #5 clk_clk = ~clk_clk;

  int errors = 0;
  int checks = 0;

  // Model: key history, per-button level and run of disagreeing samples.
  logic [2:0] m_hist1, m_hist2, m_lvl, m_pulse;
  int         m_run[3];
  int         m_cnt, m_pre;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hist1 = 3'b111; m_hist2 = 3'b111;
    m_lvl = '0; m_pulse = '0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_cnt = 0; m_pre = 0;
  endtask

  task automatic model_edge();
    logic [2:0] pressed_now;
    logic       was_paused;
    pressed_now = ~m_hist2;
    m_hist2 = m_hist1;
    m_hist1 = key_n;
    was_paused = m_lvl[1];
    m_pulse = '0;
    for (int i = 0; i < 3; i++) begin
      if (pressed_now[i] !== m_lvl[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == DB) begin
        m_lvl[i] = ~m_lvl[i];
        m_run[i] = 0;
        if (m_lvl[i]) m_pulse[i] = 1'b1;
      end
    end
    if (m_pulse[2]) begin
      m_cnt = 0; m_pre = 0;
    end else if (!was_paused) begin
      m_pre++;
      if (m_pre == TD) begin
        m_pre = 0;
        m_cnt = (m_cnt + 1) % 256;
      end
    end
  endtask

  task automatic check_all();
    chk("jump",    jump_button_export,  m_lvl[0]);
    chk("pause",   pause_button_export, m_lvl[1]);
    chk("greset",  reset_button_export, m_lvl[2]);
    chk("pulse",   press_pulse,         m_pulse);
    chk("counter", counter_8bit_export, m_cnt[7:0]);
  endtask

  task automatic step(input logic [2:0] k);
    key_n = k;
    @(posedge clk_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2 reset_reset_n = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;
  endtask

  initial begin
    int npulse;
    bit seen;
    logic [2:0] k;
    int len;

    key_n = 3'b111;
    reset_reset_n = 1'b0;
    model_reset();
    #12 check_all();
    @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;

    // Idle: counter ticks every TD cycles and wraps after 768.
    repeat (765) step(3'b111);
    chk("cnt_ff", counter_8bit_export, 8'hff);
    repeat (3) step(3'b111);
    chk("cnt_wrap", counter_8bit_export, 8'h00);

    // Jump held from cycle 0: level and pulse at cycle 6, pulse gone at 7.
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      step(3'b110);
      if (c == 5) chk("jump_c5", jump_button_export, 1'b0);
      if (c == 6) begin
        chk("jump_c6", jump_button_export, 1'b1);
        chk("pulse_c6", press_pulse, 3'b001);
      end
      if (c == 7) begin
        chk("jump_c7", jump_button_export, 1'b1);
        chk("pulse_c7", press_pulse, 3'b000);
      end
    end

    // Mid-operation async reset at counter 0x37 with jump down.
    repeat (158) step(3'b110);
    chk("cnt_37", counter_8bit_export, 8'h37);
    chk("jump_pre_rst", jump_button_export, 1'b1);
    #2 reset_reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_jump", jump_button_export, 1'b0);
    chk("rst_async_cnt", counter_8bit_export, 8'h00);
    check_all();
    @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step(3'b110);
      if (c == 5) chk("restart_c5", jump_button_export, 1'b0);
      if (c == 6) chk("restart_c6", jump_button_export, 1'b1);
    end

    // Bouncy press then bouncy release.
    do_reset();
    npulse = 0;
    repeat (3) begin
      repeat (3) step(3'b110);
      step(3'b111);
      chk("bounce_nolvl", jump_button_export, 1'b0);
    end
    repeat (8) begin
      step(3'b110);
      if (press_pulse[0]) npulse++;
    end
    chk("bounce_lvl", jump_button_export, 1'b1);
    chk("bounce_npulse", npulse, 1);
    repeat (2) begin
      repeat (2) step(3'b111);
      step(3'b110);
      chk("rel_bounce_hold", jump_button_export, 1'b1);
    end
    repeat (8) step(3'b111);
    chk("rel_done", jump_button_export, 1'b0);

    // Pause holds counter at 0x10, resumes 3 cycles after the level drops.
    do_reset();
    repeat (42) step(3'b111);
    repeat (20) step(3'b101);
    chk("pause_lvl", pause_button_export, 1'b1);
    chk("pause_hold", counter_8bit_export, 8'h10);
    for (int c = 1; c <= 9; c++) begin
      step(3'b111);
      if (c == 6) chk("pause_drop", pause_button_export, 1'b0);
      if (c == 8) chk("resume_c8", counter_8bit_export, 8'h10);
      if (c == 9) chk("resume_c9", counter_8bit_export, 8'h11);
    end

    // Reset press accepted while paused: clear beats hold.
    do_reset();
    repeat (30) step(3'b111);
    repeat (10) step(3'b101);
    seen = 1'b0;
    repeat (10) begin
      step(3'b001);
      if (press_pulse == 3'b100) begin
        seen = 1'b1;
        chk("clr_pause", pause_button_export, 1'b1);
        chk("clr_cnt", counter_8bit_export, 8'h00);
      end
    end
    chk("clr_seen", seen, 1'b1);
    repeat (10) step(3'b111);

    // Random held patterns against the model.
    do_reset();
    repeat (250) begin
      k = 3'($urandom);
      len = $urandom_range(1, 9);
      repeat (len) step(k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
